// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - read/writeback/reserve bus for the scoreboarded register file
interface reg_file_sb_if #(
  parameter int XLEN        = 32,
  parameter int REG_COUNT   = 32,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2
);
  localparam int AW = $clog2(REG_COUNT);

  logic [READ_PORTS*AW-1:0]    read_addr_i;
  logic [READ_PORTS*XLEN-1:0]  read_data_o;
  logic [READ_PORTS-1:0]       read_busy_o;
  logic [WRITE_PORTS-1:0]      write_en_i;
  logic [WRITE_PORTS*AW-1:0]   write_addr_i;
  logic [WRITE_PORTS*XLEN-1:0] write_data_i;
  logic                        reserve_en_i;
  logic [AW-1:0]               reserve_addr_i;
  logic                        flush_i;
  logic                        any_pending_o;

  modport master (
    output read_addr_i, write_en_i, write_addr_i, write_data_i,
           reserve_en_i, reserve_addr_i, flush_i,
    input  read_data_o, read_busy_o, any_pending_o
  );

  modport slave (
    input  read_addr_i, write_en_i, write_addr_i, write_data_i,
           reserve_en_i, reserve_addr_i, flush_i,
    output read_data_o, read_busy_o, any_pending_o
  );
endinterface

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-port register file with per-register pending scoreboard
module reg_file_sb #(
  parameter int XLEN        = 32,
  parameter int REG_COUNT   = 32,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  parameter int BYPASS      = 1,
  parameter int ZERO_REG    = 1
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_sb_if.slave bus
);
  localparam int AW = $clog2(REG_COUNT);

  logic [XLEN-1:0]      mem_q [REG_COUNT];
  logic [XLEN-1:0]      mem_d [REG_COUNT];
  logic [REG_COUNT-1:0] pending_q;
  logic [REG_COUNT-1:0] pending_d;

  logic [AW-1:0]        wr_addr [WRITE_PORTS];
  logic [XLEN-1:0]      wr_data [WRITE_PORTS];
  logic [AW-1:0]        rd_addr [READ_PORTS];
  logic [XLEN-1:0]      rd_data [READ_PORTS];
  logic [READ_PORTS-1:0] rd_busy;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  for (genvar p = 0; p < WRITE_PORTS; p++) begin : g_wr_unpack
    assign wr_addr[p] = bus.write_addr_i[p*AW +: AW];
    assign wr_data[p] = bus.write_data_i[p*XLEN +: XLEN];
  end

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd_pack
    assign rd_addr[k]                       = bus.read_addr_i[k*AW +: AW];
    assign bus.read_data_o[k*XLEN +: XLEN] = rd_data[k];
    assign bus.read_busy_o[k]              = rd_busy[k];
  end

  // Priority: writeback clears, reserve sets over it, flush clears everything.
  always_comb begin
    mem_d     = mem_q;
    pending_d = pending_q;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      if (bus.write_en_i[p]) begin
        if (!is_zero(wr_addr[p])) begin
          mem_d[wr_addr[p]] = wr_data[p];
        end
        pending_d[wr_addr[p]] = 1'b0;
      end
    end
    if (bus.reserve_en_i && !is_zero(bus.reserve_addr_i)) begin
      pending_d[bus.reserve_addr_i] = 1'b1;
    end
    if (bus.flush_i) begin
      pending_d = '0;
    end
    if (ZERO_REG != 0) begin
      mem_d[0]     = '0;
      pending_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        mem_q[r] <= '0;
      end
      pending_q <= '0;
    end else begin
      mem_q     <= mem_d;
      pending_q <= pending_d;
    end
  end

  // Later write ports overwrite earlier matches, so the youngest producer forwards.
  always_comb begin
    for (int k = 0; k < READ_PORTS; k++) begin
      rd_data[k] = mem_q[rd_addr[k]];
      rd_busy[k] = pending_q[rd_addr[k]];
      if (BYPASS != 0) begin
        for (int p = 0; p < WRITE_PORTS; p++) begin
          if (bus.write_en_i[p] && (wr_addr[p] == rd_addr[k])) begin
            rd_data[k] = wr_data[p];
            rd_busy[k] = 1'b0;
          end
        end
      end
      if (is_zero(rd_addr[k]) || rst) begin
        rd_data[k] = '0;
        rd_busy[k] = 1'b0;
      end
    end
  end

  assign bus.any_pending_o = |pending_q;
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor to the core's GP register file, with configurable read ports, write ports and depth. It adds a per-register pending (scoreboard) bit, set when an instruction that writes a register issues and cleared at writeback. It also adds an optional write-to-read bypass and a pipeline flush. It sits between decode/issue (read, reserve) and writeback.

Parameters:
XLEN, 32, data word width
REG_COUNT, 32, number of architectural registers (power of 2, >=2)
READ_PORTS, 2, number of independent read ports (1..4)
WRITE_PORTS, 2, number of writeback ports (1..2); higher index = younger
BYPASS, 1, 1 = same-cycle writeback data forwarded to reads; 0 = reads see the array only
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never pending

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
read_addr_i  in  READ_PORTS*AW  packed read addresses, port k at [k*AW +: AW]; AW = $clog2(REG_COUNT)
read_data_o  out  READ_PORTS*XLEN  packed read data, combinational
read_busy_o  out  READ_PORTS  operand k not yet available (pending, not satisfied by bypass)
write_en_i  in  WRITE_PORTS  writeback enable per port
write_addr_i  in  WRITE_PORTS*AW  writeback addresses
write_data_i  in  WRITE_PORTS*XLEN  writeback data
reserve_en_i  in  1  mark reserve_addr_i pending (instruction issued)
reserve_addr_i  in  AW  destination being reserved
flush_i  in  1  clear all pending bits
any_pending_o  out  1  OR of all pending bits, registered state

Behaviour:
- State: mem[REG_COUNT] of XLEN bits and pending[REG_COUNT] of 1 bit.
- While rst is high, all mem = 0 and all pending = 0, asynchronously. Resulting outputs: read_data_o = 0, read_busy_o = 0, any_pending_o = 0.
- Write: on the clock edge, for each port p with write_en_i[p] set, mem[write_addr_i[p]] <= write_data_i[p].
  - Two ports writing the same address in one cycle: the highest-index port's data is stored.
- Pending update per register r, evaluated at the clock edge in priority order:
  - flush_i: pending[r] <= 0. This beats everything, including a same-cycle reserve.
  - Otherwise, reserve_en_i && reserve_addr_i == r: pending[r] <= 1. A reserve beats a same-cycle writeback to r, because the new producer supersedes the old one.
  - Otherwise, any write_en_i[p] with write_addr_i[p] == r: pending[r] <= 0.
  - A writeback to a non-pending register is legal: the data is written and pending stays 0.
- Read (combinational), per port k, with a = read_addr_i[k]:
  - ZERO_REG && a == 0: data = 0, busy = 0.
  - Otherwise, BYPASS && a matches an enabled write port: data = write_data_i of the highest-index matching port, busy = 0.
  - Otherwise: data = mem[a], busy = pending[a].
  - Reserve does not affect reads in the same cycle; it takes effect from the next cycle.
- ZERO_REG = 1: writes and reserves to address 0 are discarded (no storage for mem[0] is required), and pending[0] is constantly 0.
- Read latency is 0 cycles. Write-to-read latency is 0 cycles with BYPASS, 1 cycle without.
- any_pending_o is computed from registered pending bits only.
- Addresses >= REG_COUNT cannot occur (power-of-2 depth).
- rst asserted mid-operation discards any in-flight write that cycle.

Test Plan:
1. Reset: assert rst for 2 cycles with write_en_i = 2'b11 -> after release, all read_data_o = 0, read_busy_o = 0, any_pending_o = 0.
2. Basic write/read: port0 writes x5 = 0xDEADBEEF; next cycle read_addr = 5 -> data 0xDEADBEEF. Write x0 = 0x1234 -> reads 0.
3. Dual-port collision: port0 writes x7 = 0x11 and port1 writes x7 = 0x22 in the same cycle -> x7 reads 0x22. Same-cycle read with BYPASS = 1 -> 0x22.
4. Scoreboard: reserve x3 -> next cycle busy = 1 on a port reading x3 and any_pending_o = 1. Writeback x3 = 0x55 -> same cycle busy = 0 and data 0x55 (BYPASS = 1), then busy stays 0.
5. Reserve/writeback race: x9 pending; in one cycle reserve x9 and write x9 = 0xAA -> x9 = 0xAA and still pending. Reserve x4 with flush_i in the same cycle -> x4 not pending.
6. BYPASS = 0 build: write x2 = 0x77 while reading x2 -> old value 0 this cycle, 0x77 next cycle. A pending reg being written reads busy = 1 in the write cycle.
